encoder_frontend: RTL and testbench

//  Input-conditioning stage between the GPIO pads and the RGB mixer core.

---
 rtl/encoder_frontend.sv | 173 +++++++++++++++++
 tb/tb_encoder_frontend.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/encoder_frontend.sv
// ---------------------------------------------------------------------------
// encoder_frontend
//   Conditions the raw quadrature encoder pads before the RGB mixer core.
//   Each A/B pad bit is synchronised through two flops and then debounced,
//   and every bit is handled independently. The debounced pair of each channel
//   is decoded 4x into one-cycle step strobes with a direction bit. Illegal
//   transitions, where both bits change at once, set a sticky error bit.
//
// Parameters
//   NUM_ENC          number of encoder channels (one A/B pair each)
//   DEBOUNCE_CYCLES  cycles a new level must persist (1..65535)
//
// Ports
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   enc_a_in    in   raw pad A inputs (asynchronous to clk)
//   enc_b_in    in   raw pad B inputs (asynchronous to clk)
//   enc_a_out   out  debounced A levels
//   enc_b_out   out  debounced B levels
//   step_valid  out  one-cycle pulse per legal quadrature edge
//   step_dir    out  1 = forward, 0 = reverse; qualified by step_valid
//   err_sticky  out  set on an illegal transition, held until err_clr
//   err_clr     in   synchronous clear of all err_sticky bits
// ---------------------------------------------------------------------------
module encoder_frontend #(
  parameter int NUM_ENC         = 3,
  parameter int DEBOUNCE_CYCLES = 255
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_ENC-1:0] enc_a_in,
  input  logic [NUM_ENC-1:0] enc_b_in,
  output logic [NUM_ENC-1:0] enc_a_out,
  output logic [NUM_ENC-1:0] enc_b_out,
  output logic [NUM_ENC-1:0] step_valid,
  output logic [NUM_ENC-1:0] step_dir,
  output logic [NUM_ENC-1:0] err_sticky,
  input  logic               err_clr
);

  // A bits occupy [NUM_ENC-1:0] and B bits occupy [2*NUM_ENC-1:NUM_ENC]
  // in the packed per-bit vectors.
  localparam int NB = 2 * NUM_ENC;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  // A level that is stable from reset release reaches the debounced output at
  // edge DEBOUNCE_CYCLES+2. Decode therefore stays disarmed through the
  // following edge, so that prev captures that level and does not report it
  // as a step or an error.
  localparam int AW = $clog2(DEBOUNCE_CYCLES + 4);
  localparam logic [AW-1:0] ARM_MAX = AW'(DEBOUNCE_CYCLES + 3);

  logic [NB-1:0]      w_raw;
  logic [NB-1:0]      r_s1;
  logic [NB-1:0]      r_s2;
  logic [NB-1:0]      r_db;
  logic [CW-1:0]      r_cnt [NB];
  logic [AW-1:0]      r_arm_cnt;
  logic               w_armed;
  logic [NUM_ENC-1:0] w_cur_a;
  logic [NUM_ENC-1:0] w_cur_b;
  logic [NUM_ENC-1:0] r_prev_a;
  logic [NUM_ENC-1:0] r_prev_b;
  logic [NUM_ENC-1:0] w_step;
  logic [NUM_ENC-1:0] w_fwd;
  logic [NUM_ENC-1:0] w_illegal;
  logic [NUM_ENC-1:0] r_step_valid;
  logic [NUM_ENC-1:0] r_step_dir;
  logic [NUM_ENC-1:0] r_err;

  assign w_raw   = {enc_b_in, enc_a_in};
  assign w_cur_a = r_db[NUM_ENC-1:0];
  assign w_cur_b = r_db[NB-1:NUM_ENC];
  assign w_armed = (r_arm_cnt == ARM_MAX);

  // Two-flop synchroniser for every raw pad bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= w_raw;
      r_s2 <= r_s1;
    end
  end

  // Per-bit debounce. Any return to the current output level restarts the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_db <= '0;
      for (int i = 0; i < NB; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (r_s2[i] == r_db[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_db[i]  <= r_s2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  // Arm counter: saturates once decode is allowed to report.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_arm_cnt <= '0;
    end else if (!w_armed) begin
      r_arm_cnt <= r_arm_cnt + AW'(1);
    end else begin
      r_arm_cnt <= r_arm_cnt;
    end
  end

  // Quadrature decode of the current debounced pair against the previous pair.
  // On a single-bit change the move is forward exactly when new A differs from
  // old B; this covers 00->10->11->01->00.
  always_comb begin
    w_step    = '0;
    w_fwd     = '0;
    w_illegal = '0;
    for (int c = 0; c < NUM_ENC; c++) begin
      case ({w_cur_a[c] ^ r_prev_a[c], w_cur_b[c] ^ r_prev_b[c]})
        2'b10, 2'b01: begin
          w_step[c] = 1'b1;
          w_fwd[c]  = w_cur_a[c] ^ r_prev_b[c];
        end
        2'b11: begin
          w_illegal[c] = 1'b1;
        end
        default: begin
          w_step[c] = 1'b0;
        end
      endcase
    end
  end

  // Registered decode outputs. prev always follows the debounced pair. While
  // disarmed, this lets prev settle without reporting a step or an error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev_a     <= '0;
      r_prev_b     <= '0;
      r_step_valid <= '0;
      r_step_dir   <= '0;
      r_err        <= '0;
    end else begin
      r_prev_a <= w_cur_a;
      r_prev_b <= w_cur_b;
      if (w_armed) begin
        r_step_valid <= w_step;
        r_step_dir   <= (w_step & w_fwd) | (~w_step & r_step_dir);
        // A new error in the same cycle as err_clr wins over the clear.
        r_err        <= (r_err & ~{NUM_ENC{err_clr}}) | w_illegal;
      end else begin
        r_step_valid <= '0;
        r_step_dir   <= r_step_dir;
        r_err        <= r_err & ~{NUM_ENC{err_clr}};
      end
    end
  end

  assign enc_a_out  = w_cur_a;
  assign enc_b_out  = w_cur_b;
  assign step_valid = r_step_valid;
  assign step_dir   = r_step_dir;
  assign err_sticky = r_err;

endmodule

// File: tb/tb_encoder_frontend.sv
// ---------------------------------------------------------------------------
// tb_encoder_frontend
//   Directed bench for encoder_frontend with NUM_ENC=3 and DEBOUNCE_CYCLES=4.
//   Inputs are driven 1 time unit after a rising edge, and outputs are sampled
//   at the same point. "Edge n" means the n-th rising edge after a change.
// ---------------------------------------------------------------------------
module tb_encoder_frontend;

  logic       clk;
  logic       reset_n;
  logic [2:0] enc_a_in;
  logic [2:0] enc_b_in;
  logic [2:0] enc_a_out;
  logic [2:0] enc_b_out;
  logic [2:0] step_valid;
  logic [2:0] step_dir;
  logic [2:0] err_sticky;
  logic       err_clr;

  int n_tests;
  int n_fail;
  int cnt_step [3];
  int cnt_fwd  [3];

  encoder_frontend #(
    .NUM_ENC        (3),
    .DEBOUNCE_CYCLES(4)
  ) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enc_a_in  (enc_a_in),
    .enc_b_in  (enc_b_in),
    .enc_a_out (enc_a_out),
    .enc_b_out (enc_b_out),
    .step_valid(step_valid),
    .step_dir  (step_dir),
    .err_sticky(err_sticky),
    .err_clr   (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_counts();
    for (int c = 0; c < 3; c++) begin
      cnt_step[c] = 0;
      cnt_fwd[c]  = 0;
    end
  endtask

  // Advance n rising edges, sample 1 unit after each one, and tally the strobes.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      for (int c = 0; c < 3; c++) begin
        if (step_valid[c] === 1'b1) cnt_step[c]++;
        if (step_valid[c] === 1'b1 && step_dir[c] === 1'b1) cnt_fwd[c]++;
      end
    end
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    enc_a_in = 3'b000;
    enc_b_in = 3'b000;
    err_clr  = 1'b0;
    clr_counts();

    // Reset state
    tick(2);
    check("rst_a_out", 32'(enc_a_out), 32'h0);
    check("rst_b_out", 32'(enc_b_out), 32'h0);
    check("rst_step_valid", 32'(step_valid), 32'h0);
    check("rst_step_dir", 32'(step_dir), 32'h0);
    check("rst_err", 32'(err_sticky), 32'h0);
    reset_n = 1'b1;
    tick(12);

    // 1: ch0 A rises; output at edge 6, forward step at edge 7 only
    clr_counts();
    enc_a_in[0] = 1'b1;
    tick(5);
    check("t1_a0_edge5", 32'(enc_a_out[0]), 32'h0);
    tick(1);
    check("t1_a0_edge6", 32'(enc_a_out[0]), 32'h1);
    check("t1_sv_edge6", 32'(step_valid), 32'h0);
    tick(1);
    check("t1_sv_edge7", 32'(step_valid), 32'h1);
    check("t1_dir_edge7", 32'(step_dir[0]), 32'h1);
    tick(1);
    check("t1_sv_edge8", 32'(step_valid), 32'h0);
    tick(4);
    check("t1_cnt0", 32'(cnt_step[0]), 32'h1);
    check("t1_quiet12", 32'(cnt_step[1] + cnt_step[2]), 32'h0);

    // 2: ch1 A 3-cycle bounce is filtered; a later hold goes through
    clr_counts();
    enc_a_in[1] = 1'b1;
    tick(3);
    enc_a_in[1] = 1'b0;
    tick(10);
    check("t2_a1_bounce", 32'(enc_a_out[1]), 32'h0);
    check("t2_sv1_bounce", 32'(cnt_step[1]), 32'h0);
    enc_a_in[1] = 1'b1;
    tick(5);
    check("t2_a1_edge5", 32'(enc_a_out[1]), 32'h0);
    tick(1);
    check("t2_a1_edge6", 32'(enc_a_out[1]), 32'h1);
    tick(3);
    check("t2_cnt1", 32'(cnt_step[1]), 32'h1);
    check("t2_fwd1", 32'(cnt_fwd[1]), 32'h1);

    // 3: ch2 full reverse cycle 00->01->11->10->00
    clr_counts();
    enc_b_in[2] = 1'b1;
    tick(10);
    enc_a_in[2] = 1'b1;
    tick(10);
    enc_b_in[2] = 1'b0;
    tick(10);
    enc_a_in[2] = 1'b0;
    tick(10);
    check("t3_cnt2", 32'(cnt_step[2]), 32'h4);
    check("t3_fwd2", 32'(cnt_fwd[2]), 32'h0);
    check("t3_quiet01", 32'(cnt_step[0] + cnt_step[1]), 32'h0);
    check("t3_err", 32'(err_sticky), 32'h0);
    check("t3_ab2", 32'({enc_a_out[2], enc_b_out[2]}), 32'h0);

    // 4: ch0 10 -> 01 on one raw edge is illegal; clear, then clear vs new error
    clr_counts();
    enc_a_in[0] = 1'b0;
    enc_b_in[0] = 1'b1;
    tick(5);
    check("t4_a0_edge5", 32'(enc_a_out[0]), 32'h1);
    tick(1);
    check("t4_ab0_edge6", 32'({enc_a_out[0], enc_b_out[0]}), 32'h1);
    tick(1);
    check("t4_err_set", 32'(err_sticky), 32'h1);
    check("t4_sv_edge7", 32'(step_valid), 32'h0);
    tick(3);
    check("t4_cnt0", 32'(cnt_step[0]), 32'h0);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("t4_err_clr", 32'(err_sticky), 32'h0);
    enc_a_in[0] = 1'b1;
    enc_b_in[0] = 1'b0;
    tick(6);
    check("t4_ab0_back", 32'({enc_a_out[0], enc_b_out[0]}), 32'h2);
    check("t4_err_pre", 32'(err_sticky), 32'h0);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("t4_set_wins", 32'(err_sticky), 32'h1);

    // 5: pads high through reset release produce no step and no error
    reset_n  = 1'b0;
    enc_a_in = 3'b111;
    enc_b_in = 3'b111;
    tick(2);
    check("t5_rst_err", 32'(err_sticky), 32'h0);
    check("t5_rst_a", 32'(enc_a_out), 32'h0);
    reset_n = 1'b1;
    clr_counts();
    tick(5);
    check("t5_a_edge5", 32'(enc_a_out), 32'h0);
    tick(1);
    check("t5_a_edge6", 32'(enc_a_out), 32'h7);
    check("t5_b_edge6", 32'(enc_b_out), 32'h7);
    tick(12);
    check("t5_no_steps", 32'(cnt_step[0] + cnt_step[1] + cnt_step[2]), 32'h0);
    check("t5_no_err", 32'(err_sticky), 32'h0);

    // 6: reset mid-debounce clears outputs at once; a full hold is needed after
    enc_a_in[0] = 1'b0;
    tick(4);
    reset_n = 1'b0;
    #1;
    check("t6_async_a", 32'(enc_a_out), 32'h0);
    check("t6_async_b", 32'(enc_b_out), 32'h0);
    check("t6_async_sv", 32'(step_valid), 32'h0);
    check("t6_async_err", 32'(err_sticky), 32'h0);
    tick(1);
    reset_n = 1'b1;
    tick(5);
    check("t6_a_edge5", 32'(enc_a_out), 32'h0);
    check("t6_b_edge5", 32'(enc_b_out), 32'h0);
    tick(1);
    check("t6_a_edge6", 32'(enc_a_out), 32'h6);
    check("t6_b_edge6", 32'(enc_b_out), 32'h7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
